// File: rtl/button_debounce_pkg.sv
// Shared constants for the DE0-Nano key conditioning logic.
// Keys on the board are active-low, so an idle (released) key reads high.
package button_debounce_pkg;

    // 1 ms of stability at a 50 MHz system clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

    // Smallest counter width whose range covers DEFAULT_DEBOUNCE_CYCLES.
    localparam int unsigned DEFAULT_CNT_W = 16;

    // Level of a released key; synchronisers and outputs start here.
    localparam logic KEY_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/button_debounce_channel.sv
// One key channel: two-flop synchroniser, stability counter, debounced
// output flop and one-cycle press/release strobes.
module button_debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter logic        RESET_BIT       = KEY_IDLE_LEVEL
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic debounced,
    output logic fall_pulse,
    output logic rise_pulse,
    output logic settling
);

    // The counter value at which the new level has been stable long enough.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             debounced_q, debounced_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;
    logic             rise_q, rise_d;
    logic             settling_q, settling_d;

    // Next-state logic: synchronise, then only accept a level that held for the whole window.
    always_comb begin
        sync1_d     = button_raw;
        sync2_d     = sync1_q;
        debounced_d = debounced_q;
        cnt_d       = cnt_q;
        fall_d      = 1'b0;
        rise_d      = 1'b0;
        settling_d  = sync2_q ^ debounced_q;

        if (sync2_q == debounced_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            debounced_d = sync2_q;
            cnt_d       = '0;
            fall_d      = ~sync2_q;
            rise_d      = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State flops; reset returns the channel to the idle key level with no strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= RESET_BIT;
            sync2_q     <= RESET_BIT;
            debounced_q <= RESET_BIT;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
            rise_q      <= 1'b0;
            settling_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            debounced_q <= debounced_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
            rise_q      <= rise_d;
            settling_q  <= settling_d;
        end
    end

    assign debounced  = debounced_q;
    assign fall_pulse = fall_q;
    assign rise_pulse = rise_q;
    assign settling   = settling_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces the raw KEY pins before they reach the button PIO.
// Each channel is independent; the top only combines the settling flags.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned       WIDTH           = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned       CNT_W           = DEFAULT_CNT_W,
    parameter logic [WIDTH-1:0]  RESET_LEVEL     = {WIDTH{KEY_IDLE_LEVEL}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] button_raw,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] rise_pulse,
    output logic             settling
);

    logic [WIDTH-1:0] settling_flags;

    // One debounce channel per key pin.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_BIT       (RESET_LEVEL[i])
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .button_raw (button_raw[i]),
            .debounced  (debounced[i]),
            .fall_pulse (fall_pulse[i]),
            .rise_pulse (rise_pulse[i]),
            .settling   (settling_flags[i])
        );
    end

    // Any channel with a pending level change counts as settling.
    assign settling = |settling_flags;

endmodule
